// File: rtl/enigma_seq_ctrl_if.sv
// Handshake and data bundle between the symbol source, the sequencer and the Enigma core.
// The sequencer takes the slave view; the environment driving it takes the master view.
interface enigma_seq_ctrl_if #(
  parameter int LEN_W  = 8,
  parameter int SYMB_W = 7
);
  logic                     msg_start_i;
  logic [LEN_W-1:0]         msg_len_i;
  logic                     symb_val_i;
  logic signed [SYMB_W-1:0] symbol_i;
  logic                     symb_rdy_o;
  logic                     rotors_rst_o;
  logic                     core_val_o;
  logic signed [SYMB_W-1:0] core_symb_o;
  logic                     core_val_i;
  logic signed [SYMB_W-1:0] core_symb_i;
  logic                     symb_val_o;
  logic signed [SYMB_W-1:0] symbol_o;
  logic                     last_o;
  logic                     done_o;
  logic                     err_o;
  logic                     busy_o;

  modport slave (
    input  msg_start_i, msg_len_i, symb_val_i, symbol_i, core_val_i, core_symb_i,
    output symb_rdy_o, rotors_rst_o, core_val_o, core_symb_o,
           symb_val_o, symbol_o, last_o, done_o, err_o, busy_o
  );

  modport master (
    output msg_start_i, msg_len_i, symb_val_i, symbol_i, core_val_i, core_symb_i,
    input  symb_rdy_o, rotors_rst_o, core_val_o, core_symb_o,
           symb_val_o, symbol_o, last_o, done_o, err_o, busy_o
  );
endinterface

// File: rtl/enigma_seq_ctrl.sv
// Message sequencer for the Enigma core: pulses rotor reset per message, gates symbols
// into the core one per cycle, counts coded symbols back and flags last/done/timeout.
module enigma_seq_ctrl #(
  parameter int LEN_W   = 8,
  parameter int SYMB_W  = 7,
  parameter int TIMEOUT = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  enigma_seq_ctrl_if.slave bus
);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ROTRST = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]               r_state;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_sent;
  logic [LEN_W-1:0]         r_recv;
  logic [TO_W-1:0]          r_to;
  logic                     r_err;
  logic                     r_core_val;
  logic signed [SYMB_W-1:0] r_core_symb;
  logic                     r_symb_val;
  logic signed [SYMB_W-1:0] r_symbol;
  logic                     r_last;

  logic             w_rdy;
  logic             w_accept;
  logic             w_ret;
  logic             w_count;
  logic             w_timeout;
  logic [LEN_W-1:0] w_sent_next;
  logic [LEN_W-1:0] w_recv_next;

  assign w_rdy       = (r_state == S_RUN) && (r_sent < r_len);
  assign w_accept    = w_rdy && bus.symb_val_i;
  // Returns beyond the message length, or outside a message, are dropped.
  assign w_ret       = (r_state != S_IDLE) && bus.core_val_i && (r_recv != r_len);
  assign w_sent_next = r_sent + {{(LEN_W-1){1'b0}}, w_accept};
  assign w_recv_next = r_recv + {{(LEN_W-1){1'b0}}, w_ret};
  assign w_count     = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                       (r_sent > r_recv) && !bus.core_val_i;
  assign w_timeout   = w_count && (r_to == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_sent      <= '0;
      r_recv      <= '0;
      r_to        <= '0;
      r_err       <= 1'b0;
      r_core_val  <= 1'b0;
      r_core_symb <= '0;
      r_symb_val  <= 1'b0;
      r_symbol    <= '0;
      r_last      <= 1'b0;
    end else begin
      r_core_val <= w_accept;
      if (w_accept) r_core_symb <= bus.symbol_i;
      r_symb_val <= w_ret;
      if (w_ret) r_symbol <= bus.core_symb_i;
      r_last <= w_ret && (w_recv_next == r_len);
      r_sent <= w_sent_next;
      r_recv <= w_recv_next;
      if (bus.core_val_i)  r_to <= '0;
      else if (w_count)    r_to <= r_to + 1'b1;

      // NOTE: non-blocking assignments let the later per-state writes below override the
      // default counter updates above within the same clock edge.
      case (r_state)
        S_IDLE: begin
          if (bus.msg_start_i) begin
            r_len   <= bus.msg_len_i;
            r_sent  <= '0;
            r_recv  <= '0;
            r_to    <= '0;
            r_err   <= 1'b0;
            r_state <= S_ROTRST;
          end
        end
        S_ROTRST: r_state <= (r_len == '0) ? S_DONE : S_RUN;
        S_RUN: begin
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_accept && (w_sent_next == r_len)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else if (w_recv_next == r_len) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.symb_rdy_o   = w_rdy;
  assign bus.rotors_rst_o = (r_state == S_ROTRST);
  assign bus.core_val_o   = r_core_val;
  assign bus.core_symb_o  = r_core_symb;
  assign bus.symb_val_o   = r_symb_val;
  assign bus.symbol_o     = r_symbol;
  assign bus.last_o       = r_last;
  assign bus.done_o       = (r_state == S_DONE);
  assign bus.err_o        = r_err;
  assign bus.busy_o       = (r_state != S_IDLE);
endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// Self-checking bench for enigma_seq_ctrl: a behavioural message model checked every cycle,
// a delay-line core emulator, and directed plus randomized messages with literal pins.
module tb_enigma_seq_ctrl;
  localparam int LEN_W   = 8;
  localparam int SYMB_W  = 7;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enigma_seq_ctrl_if #(.LEN_W(LEN_W), .SYMB_W(SYMB_W)) bus ();

  enigma_seq_ctrl #(.LEN_W(LEN_W), .SYMB_W(SYMB_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_sym(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core emulator: returns each symbol plus one after 'lat' cycles, unless muted.
  int   lat  = 1;
  bit   mute = 1'b0;
  logic       dl_v [8] = '{default: 1'b0};
  logic [6:0] dl_s [8] = '{default: 7'd0};
  always @(posedge clk) begin
    #1;
    for (int k = 7; k > 0; k--) begin
      dl_v[k] = dl_v[k-1];
      dl_s[k] = dl_s[k-1];
    end
    dl_v[0] = bus.core_val_o;
    dl_s[0] = bus.core_symb_o;
    bus.core_val_i  = !mute && dl_v[lat];
    bus.core_symb_i = dl_s[lat] + 7'd1;
  end

  // Behavioural message model: what each output must be in the current cycle.
  typedef enum {M_IDLE, M_ROT, M_RUN, M_DRAIN, M_DONE} mphase_t;
  mphase_t    m_phase = M_IDLE;
  int         m_len = 0, m_sent = 0, m_recv = 0, m_to = 0;
  bit         m_err = 1'b0;
  bit         e_cv = 1'b0, e_sv = 1'b0, e_last = 1'b0;
  logic [6:0] e_cs = 7'd0, e_so = 7'd0;

  // Observed events for the literal checks.
  logic [6:0] out_sym [$];
  bit         out_last [$];
  logic [6:0] cv_sym [$];
  int rot_cnt = 0, rot_cyc = -1, done_cnt = 0, done_cyc = -1, rdy_hi = 0;
  int acc_cnt = 0, cvi_cnt = 0, last_cvi_cyc = -1;
  bit err_at_done = 1'b0;

  always @(negedge clk) begin
    bit ready, acc, ret, waiting, timed_out;
    mphase_t nxt;
    int to_n;
    ready = (m_phase == M_RUN) && (m_sent < m_len);
    check("symb_rdy_o", bus.symb_rdy_o, ready);
    check("rotors_rst_o", bus.rotors_rst_o, m_phase == M_ROT);
    check("done_o", bus.done_o, m_phase == M_DONE);
    check("busy_o", bus.busy_o, m_phase != M_IDLE);
    check("err_o", bus.err_o, m_err);
    check("core_val_o", bus.core_val_o, e_cv);
    check_sym("core_symb_o", bus.core_symb_o, e_cs);
    check("symb_val_o", bus.symb_val_o, e_sv);
    check_sym("symbol_o", bus.symbol_o, e_so);
    check("last_o", bus.last_o, e_last);

    if (bus.symb_val_o) begin
      out_sym.push_back(bus.symbol_o);
      out_last.push_back(bus.last_o);
    end
    if (bus.core_val_o) cv_sym.push_back(bus.core_symb_o);
    if (bus.rotors_rst_o) begin rot_cnt++; rot_cyc = cyc; end
    if (bus.done_o) begin done_cnt++; done_cyc = cyc; err_at_done = bus.err_o; end
    if (bus.symb_rdy_o) rdy_hi++;
    if (bus.symb_rdy_o && bus.symb_val_i) acc_cnt++;
    if (bus.core_val_i) begin cvi_cnt++; last_cvi_cyc = cyc; end

    if (rst) begin
      m_phase = M_IDLE; m_len = 0; m_sent = 0; m_recv = 0; m_to = 0; m_err = 1'b0;
      e_cv = 1'b0; e_cs = 7'd0; e_sv = 1'b0; e_so = 7'd0; e_last = 1'b0;
    end else begin
      acc       = ready && bus.symb_val_i;
      ret       = (m_phase != M_IDLE) && bus.core_val_i && (m_recv < m_len);
      waiting   = (m_phase == M_RUN || m_phase == M_DRAIN) && (m_sent > m_recv) && !bus.core_val_i;
      timed_out = waiting && (m_to + 1 >= TIMEOUT);
      to_n      = bus.core_val_i ? 0 : (waiting ? m_to + 1 : m_to);
      e_cv = acc;
      if (acc) e_cs = bus.symbol_i;
      e_sv = ret;
      if (ret) e_so = bus.core_symb_i;
      e_last = ret && (m_recv + 1 == m_len);
      nxt = m_phase;
      case (m_phase)
        M_IDLE:  if (bus.msg_start_i) nxt = M_ROT;
        M_ROT:   nxt = (m_len == 0) ? M_DONE : M_RUN;
        M_RUN:   if (timed_out) nxt = M_DONE; else if (acc && m_sent + 1 == m_len) nxt = M_DRAIN;
        M_DRAIN: if (timed_out) nxt = M_DONE; else if (m_recv + int'(ret) == m_len) nxt = M_DONE;
        default: nxt = M_IDLE;
      endcase
      if (timed_out) m_err = 1'b1;
      m_sent += int'(acc);
      m_recv += int'(ret);
      m_to = to_n;
      if (m_phase == M_IDLE && bus.msg_start_i) begin
        m_len = int'(bus.msg_len_i); m_sent = 0; m_recv = 0; m_to = 0; m_err = 1'b0;
      end
      m_phase = nxt;
    end
    cyc++;
  end

  int b_out, b_cv, b_rot, b_done, b_rdy, b_acc, b_cvi;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_out = out_sym.size(); b_cv = cv_sym.size(); b_rot = rot_cnt; b_done = done_cnt;
    b_rdy = rdy_hi; b_acc = acc_cnt; b_cvi = cvi_cnt;
  endtask

  task automatic start_msg(input int len, output int c0);
    bus.msg_len_i   = LEN_W'(len);
    bus.msg_start_i = 1'b1;
    c0 = cyc;
    tick();
    bus.msg_start_i = 1'b0;
  endtask

  task automatic send(input int len, input logic [6:0] syms[$], input bit toggle, input int start_at);
    int idx = 0, guard = 0;
    bit ph = 1'b1, acc;
    while (idx < len && guard < 2000) begin
      bus.symb_val_i  = toggle ? ph : 1'b1;
      ph = !ph;
      bus.symbol_i    = syms[idx];
      bus.msg_start_i = (guard == start_at);
      if (guard == start_at) bus.msg_len_i = 8'd9;
      @(negedge clk);
      acc = bus.symb_val_i && bus.symb_rdy_o;
      tick();
      if (acc) idx++;
      guard++;
    end
    bus.symb_val_i  = 1'b0;
    bus.msg_start_i = 1'b0;
    if (guard >= 2000) check("send_budget", idx, len);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == b_done && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", done_cnt - b_done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int c0, c1, mism, lcnt, len;
    logic [6:0] q[$];
    rst = 1'b1;
    bus.msg_start_i = 1'b0; bus.msg_len_i = '0; bus.symb_val_i = 1'b0; bus.symbol_i = '0;
    bus.core_val_i = 1'b0; bus.core_symb_i = '0;
    tick(); tick();
    @(negedge clk);
    check("reset_busy", bus.busy_o, 0);
    check("reset_core_symb", bus.core_symb_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Length 3, 1-cycle loopback, 5,6,7 back to back.
    lat = 1; mark();
    q = {7'd5, 7'd6, 7'd7};
    start_msg(3, c0);
    send(3, q, 1'b0, -1);
    wait_done(40);
    check("t1_outputs", out_sym.size() - b_out, 3);
    check_sym("t1_out0", out_sym[b_out], 7'd6);
    check_sym("t1_out1", out_sym[b_out+1], 7'd7);
    check_sym("t1_out2", out_sym[b_out+2], 7'd8);
    check("t1_last_flags", {out_last[b_out], out_last[b_out+1], out_last[b_out+2]}, 3'b001);
    check("t1_rot_pulses", rot_cnt - b_rot, 1);
    check("t1_rot_cycle", rot_cyc, c0 + 1);
    check("t1_done_cycle", done_cyc, last_cvi_cyc + 1);
    check("t1_accepts", acc_cnt - b_acc, 3);
    repeat (3) tick();

    // Length 0.
    mark();
    start_msg(0, c0);
    wait_done(10);
    check("t2_rot_cycle", rot_cyc, c0 + 1);
    check("t2_done_cycle", done_cyc, c0 + 2);
    check("t2_rdy_never", rdy_hi - b_rdy, 0);
    repeat (3) tick();

    // Length 4, toggling valid, core latency 3.
    lat = 3; mark();
    q = {7'd10, 7'd20, 7'd30, 7'd40};
    start_msg(4, c0);
    send(4, q, 1'b1, -1);
    wait_done(60);
    check("t3_core_pulses", cv_sym.size() - b_cv, 4);
    for (int i = 0; i < 4; i++) check_sym("t3_core_order", cv_sym[b_cv+i], q[i]);
    check("t3_outputs", out_sym.size() - b_out, 4);
    check_sym("t3_out3", out_sym[b_out+3], 7'd41);
    check("t3_last_flags", {out_last[b_out], out_last[b_out+1], out_last[b_out+2], out_last[b_out+3]}, 4'b0001);
    repeat (6) tick();

    // Silent core, length 2: timeout.
    lat = 1; mute = 1'b1; mark();
    q = {7'd1, 7'd2};
    start_msg(2, c0);
    send(2, q, 1'b0, -1);
    wait_done(40);
    check("t4_done_cycle", done_cyc, c0 + 19);
    check("t4_err_at_done", err_at_done, 1);
    check("t4_outputs", out_sym.size() - b_out, 0);
    tick();
    check("t4_err_sticky", bus.err_o, 1);
    mute = 1'b0; mark();
    start_msg(1, c1);
    @(negedge clk);
    check("t4_err_cleared", bus.err_o, 0);
    tick();
    q = {7'd0};
    send(1, q, 1'b0, -1);
    wait_done(20);
    repeat (3) tick();

    // Start pulse during RUN is ignored.
    lat = 2; mark();
    q = {7'd3, 7'd4, 7'd5};
    start_msg(3, c0);
    send(3, q, 1'b0, 1);
    wait_done(40);
    check("t5_outputs", out_sym.size() - b_out, 3);
    check("t5_last_on_3rd", out_last[b_out+2], 1);
    check("t5_rot_pulses", rot_cnt - b_rot, 1);
    repeat (3) tick();

    // Reset mid-DRAIN; late core returns dropped.
    lat = 5; mark();
    start_msg(3, c0);
    send(3, q, 1'b0, -1);
    check("t6_busy_in_drain", bus.busy_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", bus.busy_o, 0);
    check("t6_rst_outs", {bus.symb_rdy_o, bus.rotors_rst_o, bus.core_val_o, bus.symb_val_o,
                          bus.last_o, bus.done_o, bus.err_o}, 7'd0);
    check_sym("t6_rst_symbol", bus.symbol_o, 7'd0);
    tick();
    repeat (8) tick();
    check("t6_late_core_seen", cvi_cnt - b_cvi > 0, 1);
    check("t6_late_dropped", out_sym.size() - b_out, 0);

    // Length 255 streamed continuously.
    lat = 1; mark();
    q = {};
    for (int i = 0; i < 255; i++) q.push_back(7'($urandom));
    start_msg(255, c0);
    send(255, q, 1'b0, -1);
    wait_done(400);
    check("t7_outputs", out_sym.size() - b_out, 255);
    mism = 0; lcnt = 0;
    for (int i = 0; i < 255; i++) begin
      if (out_sym[b_out+i] !== q[i] + 7'd1) mism++;
      if (out_last[b_out+i]) lcnt++;
    end
    check("t7_symbol_mismatches", mism, 0);
    check("t7_last_count", lcnt, 1);
    check("t7_last_on_255th", out_last[b_out+254], 1);
    check("t7_no_err", bus.err_o, 0);
    repeat (3) tick();

    // Randomized messages.
    for (int m = 0; m < 8; m++) begin
      lat = $urandom_range(4, 1);
      len = $urandom_range(12, 0);
      q = {};
      for (int i = 0; i < len; i++) q.push_back(7'($urandom));
      mark();
      start_msg(len, c0);
      send(len, q, 1'($urandom), -1);
      wait_done(100);
      check("rand_outputs", out_sym.size() - b_out, len);
      repeat (6) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enigma_seq_ctrl.md
# enigma_seq_ctrl

Message sequencer for the Enigma coding core. It accepts a message start command with a length and pulses the core's rotor reset so every message begins from the home rotor position. It then gates upstream symbols into the core one per cycle, counts coded symbols returning from the core, marks the last one and reports completion or a core timeout. It sits between the symbol source and the core (`enigma_1`), replacing direct `rotors_rst_i`/`en_val_i` driving.

## Interface
- `LEN_W`, 8: width of message length and counters.
- `SYMB_W`, 7: signed symbol width.
- `TIMEOUT`, 16: max cycles allowed without a core output while symbols are outstanding.

- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `msg_start_i` in 1: start pulse; sampled only in IDLE.
- `msg_len_i` in `LEN_W`: symbols in message, sampled with `msg_start_i`.
- `symb_val_i` in 1: upstream symbol valid.
- `symbol_i` in `SYMB_W` signed: upstream plaintext/ciphertext symbol.
- `symb_rdy_o` out 1: controller accepts a symbol this cycle.
- `rotors_rst_o` out 1: rotor reset to core, one-cycle pulse.
- `core_val_o` out 1: symbol valid to core.
- `core_symb_o` out `SYMB_W` signed: symbol to core.
- `core_val_i` in 1: coded symbol valid from core.
- `core_symb_i` in `SYMB_W` signed: coded symbol from core.
- `symb_val_o` out 1: coded symbol valid downstream.
- `symbol_o` out `SYMB_W` signed: coded symbol downstream.
- `last_o` out 1: qualifies final coded symbol of message.
- `done_o` out 1: one-cycle message-complete pulse.
- `err_o` out 1: sticky timeout flag, cleared by next accepted `msg_start_i` or reset.
- `busy_o` out 1: high in any state except IDLE.

## Operation
- States: IDLE, ROTRST, RUN, DRAIN, DONE.
- IDLE: if `msg_start_i` is high, latch `msg_len_i` into `len_q`, clear `sent_cnt`, `recv_cnt` and `err_o`, then go to ROTRST.
- ROTRST: `rotors_rst_o` is high for exactly this cycle.
  - If `len_q`==0, go to DONE.
  - Otherwise go to RUN.
- RUN: `symb_rdy_o` = (`sent_cnt` < `len_q`).
  - Accept occurs when `symb_val_i & symb_rdy_o`. On accept, register `symbol_i` to `core_symb_o`, assert `core_val_o` next cycle, and increment `sent_cnt`.
  - When the accept makes `sent_cnt` equal `len_q`, go to DRAIN.
- DRAIN: `symb_rdy_o`=0. Wait until `recv_cnt` equals `len_q`, then go to DONE.
- Return path, all states except IDLE:
  - Each `core_val_i` registers `core_symb_i` to `symbol_o` with `symb_val_o`=1 and increments `recv_cnt`.
  - `last_o`=1 on the output whose `recv_cnt` increment reaches `len_q`.
  - `core_val_i` while `recv_cnt`==`len_q`, or while in IDLE, is dropped; `symb_val_o` stays 0.
- Timeout: `to_cnt` counts cycles in RUN/DRAIN where `sent_cnt` > `recv_cnt` and `core_val_i`=0. It resets on any `core_val_i`.
  - Reaching `TIMEOUT` sets `err_o` and forces DONE.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- `msg_start_i` outside IDLE is ignored.
- Counters are `LEN_W` bits and never wrap, since they are bounded by `len_q`. `len_q`=255 is legal.
- Simultaneous accept and `core_val_i` in one cycle update both counters independently.
- `rst_i` mid-message returns to IDLE immediately. In-flight core outputs after reset are dropped.

## Timing
- Reset values:
  - All outputs 0: `symb_rdy_o`, `rotors_rst_o`, `core_val_o`, `core_symb_o`, `symb_val_o`, `symbol_o`, `last_o`, `done_o`, `err_o`, `busy_o`.
  - State is IDLE and all counters are 0.
- `msg_start_i` at cycle 0 gives `rotors_rst_o` at cycle 1 and `symb_rdy_o` first high at cycle 2.
- `symb_rdy_o` is combinational from state and counters. It does not depend on `symb_val_i`.
- Accept at cycle N drives `core_val_o`/`core_symb_o` at cycle N+1, one cycle of latency.
- `core_val_i` at cycle M drives `symb_val_o`/`symbol_o`/`last_o` at cycle M+1.
- `done_o` is asserted the cycle after the final `recv_cnt` increment, which is the same cycle as `symb_val_o`/`last_o` for the final symbol.
- `busy_o` rises the cycle after `msg_start_i` and falls the cycle after `done_o`.
- Throughput is one symbol per cycle with `symb_val_i` held high.

## Test plan
- Length 3 with a 1-cycle loopback core (`core_symb_i` = `core_symb_o` + 1), symbols 5,6,7 streamed back-to-back:
  - One `rotors_rst_o` pulse.
  - Outputs 6,7,8, with `last_o` on 8.
  - `done_o` one cycle after the final `core_val_i`.
  - `symb_rdy_o` low after the third accept.
- Length 0: `rotors_rst_o` at cycle 1, `done_o` at cycle 2, `symb_rdy_o` never high.
- Length 4 with `symb_val_i` toggling every other cycle and core latency 3:
  - Exactly 4 `core_val_o` pulses, in order.
  - `recv_cnt` reaches 4 and `last_o` is on the 4th output.
- Core never responds, `TIMEOUT`=16, length 2: after 16 idle cycles with outstanding symbols, `err_o`=1 and `done_o` pulses. The next `msg_start_i` clears `err_o`.
- `msg_start_i` asserted during RUN is ignored and `len_q` is unchanged.
  - `rst_i` asserted mid-DRAIN: next cycle, all outputs are 0 and state is IDLE.
  - A late `core_val_i` after that reset produces no `symb_val_o`.
- Length 255 streamed continuously: 255 outputs, `last_o` only on the 255th, and no counter wrap.
